// File: rtl/window_generator.sv
// Sliding K x K window generator over a raster-order pixel stream.
// K-1 line buffers feed a register window; windows never straddle row or frame boundaries.
module window_generator #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  parameter int K      = 3
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic [DATA_W-1:0]        pixel_in,
  input  logic                     pixel_in_valid,
  input  logic                     frame_start,
  output logic [K*K*DATA_W-1:0]    window_out,
  output logic                     window_out_valid,
  output logic [$clog2(IMG_W)-1:0] out_col,
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic                     frame_done,
  output logic                     frame_err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_EDGE = CW'(K - 1);
  localparam logic [CW-1:0] COL_HALF = CW'((K - 1) / 2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_EDGE = RW'(K - 1);
  localparam logic [RW-1:0] ROW_HALF = RW'((K - 1) / 2);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t            state;
  state_t            eff_state;
  logic [CW-1:0]     in_col;
  logic [CW-1:0]     cur_col;
  logic [RW-1:0]     in_row;
  logic [RW-1:0]     cur_row;
  logic              at_origin;
  logic              qualify;
  logic              last_pix;
  logic [DATA_W-1:0] line_buf [K-1][IMG_W];
  logic [DATA_W-1:0] column   [K];
  logic [K*K*DATA_W-1:0] win_nxt;

  // A frame_start pulse relocates the coincident pixel (if any) to (0,0).
  always_comb begin
    at_origin = (in_col == '0) && (in_row == '0);
    cur_col   = frame_start ? '0 : in_col;
    cur_row   = frame_start ? '0 : in_row;
    eff_state = frame_start ? IDLE : state;
    qualify   = pixel_in_valid && (cur_row >= ROW_EDGE) && (cur_col >= COL_EDGE);
    last_pix  = pixel_in_valid && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
  end

  // column[K-1] is the newest row; line_buf[0] holds the row directly above it.
  always_comb begin
    column = '{default: '0};
    column[K-1] = pixel_in;
    for (int unsigned i = 0; i < K - 1; i++) begin
      column[K-2-i] = line_buf[i][cur_col];
    end
    win_nxt = window_out;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        if (c == K - 1) begin
          win_nxt[(r*K+c)*DATA_W +: DATA_W] = column[r];
        end else begin
          win_nxt[(r*K+c)*DATA_W +: DATA_W] = window_out[(r*K+c+1)*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pixel_in_valid) begin
      line_buf[0][cur_col] <= pixel_in;
      for (int unsigned i = 1; i < K - 1; i++) begin
        line_buf[i][cur_col] <= line_buf[i-1][cur_col];
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state            <= IDLE;
      in_col           <= '0;
      in_row           <= '0;
      window_out       <= '0;
      window_out_valid <= 1'b0;
      out_col          <= '0;
      out_row          <= '0;
      frame_done       <= 1'b0;
      frame_err        <= 1'b0;
    end else begin
      frame_err        <= frame_start && !at_origin;
      window_out_valid <= qualify;
      frame_done       <= last_pix;
      if (pixel_in_valid) begin
        window_out <= win_nxt;
        if (qualify) begin
          out_col <= cur_col - COL_HALF;
          out_row <= cur_row - ROW_HALF;
        end
        if (cur_col == COL_LAST) begin
          in_col <= '0;
          in_row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end else begin
          in_col <= cur_col + CW'(1);
          in_row <= cur_row;
        end
        case (eff_state)
          IDLE:    state <= FILL;
          FILL:    if (cur_row == ROW_EDGE) state <= RUN;
          RUN:     if (last_pix) state <= IDLE;
          default: state <= IDLE;
        endcase
      end else if (frame_start) begin
        in_col <= '0;
        in_row <= '0;
        state  <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_window_generator.sv
// Scoreboard bench for window_generator: K=3 and K=5 instances share one 8x6 pixel stream.
module tb_window_generator;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int WMAX = 200;

  typedef struct {
    int               cyc;
    logic [WMAX-1:0]  win;
    int               col;
    int               row;
    bit               done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic [7:0]  pixel_in;
  logic        pixel_in_valid;
  logic        frame_start;

  logic [71:0]  w3;
  logic         v3, fd3, fe3;
  logic [2:0]   oc3, or3;
  logic [199:0] w5;
  logic         v5, fd5, fe5;
  logic [2:0]   oc5, or5;

  window_generator #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .K(3)) dut3 (
    .clk(clk), .rstN(rstN), .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
    .frame_start(frame_start), .window_out(w3), .window_out_valid(v3),
    .out_col(oc3), .out_row(or3), .frame_done(fd3), .frame_err(fe3));

  window_generator #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .K(5)) dut5 (
    .clk(clk), .rstN(rstN), .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
    .frame_start(frame_start), .window_out(w5), .window_out_valid(v5),
    .out_col(oc5), .out_row(or5), .frame_done(fd5), .frame_err(fe5));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q3[$];
  exp_t q5[$];
  int   eq[$];
  logic [7:0] img [H][W];
  int   pr, pc;

  int n_checks = 0;
  int n_fail   = 0;
  int req_id = 0, ack_id = 0;
  int exp_cnt3, exp_cnt5, exp_done, exp_err;
  logic [71:0] exp_c11;
  logic [7:0]  exp_lo5, exp_hi5;

  int cnt3 = 0, cnt5 = 0, done3 = 0, done5 = 0, errs = 0;
  logic [71:0]  c11_3 = '0;
  logic [199:0] c22_5 = '0;

  function automatic void chk(input string nm, input logic [WMAX-1:0] act, input logic [WMAX-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic exp_t build(input int k);
    exp_t e;
    e.win = '0;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < k; c++)
        e.win[(r*k+c)*8 +: 8] = img[pr-k+1+r][pc-k+1+c];
    e.cyc  = cyc + 1;
    e.col  = pc - (k - 1) / 2;
    e.row  = pr - (k - 1) / 2;
    e.done = (pr == H - 1) && (pc == W - 1);
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever an instance presents a window.
  always @(negedge clk) begin
    exp_t e;
    bit   err_now;
    if (!rstN) begin
      chk("reset_flags", WMAX'({v3, fd3, fe3, v5, fd5, fe5}), WMAX'(0));
      chk("reset_win3", WMAX'(w3), WMAX'(0));
      chk("reset_win5", WMAX'(w5), WMAX'(0));
      chk("reset_pos", WMAX'({oc3, or3, oc5, or5}), WMAX'(0));
    end else begin
      if (v3) begin
        cnt3++;
        if (q3.size() == 0) chk("k3_unexpected_window", WMAX'(1), WMAX'(0));
        else begin
          e = q3.pop_front();
          chk("k3_latency", WMAX'(cyc), WMAX'(e.cyc));
          chk("k3_window", WMAX'(w3), e.win);
          chk("k3_centre", WMAX'({oc3, or3}), WMAX'({e.col[2:0], e.row[2:0]}));
          chk("k3_frame_done", WMAX'(fd3), WMAX'(e.done));
        end
        if (oc3 == 3'd1 && or3 == 3'd1) c11_3 = w3;
        if (fd3) done3++;
      end else if (fd3) chk("k3_done_without_window", WMAX'(1), WMAX'(0));
      if (v5) begin
        cnt5++;
        if (q5.size() == 0) chk("k5_unexpected_window", WMAX'(1), WMAX'(0));
        else begin
          e = q5.pop_front();
          chk("k5_latency", WMAX'(cyc), WMAX'(e.cyc));
          chk("k5_window", WMAX'(w5), e.win);
          chk("k5_centre", WMAX'({oc5, or5}), WMAX'({e.col[2:0], e.row[2:0]}));
          chk("k5_frame_done", WMAX'(fd5), WMAX'(e.done));
        end
        if (oc5 == 3'd2 && or5 == 3'd2) c22_5 = w5;
        if (fd5) done5++;
      end else if (fd5) chk("k5_done_without_window", WMAX'(1), WMAX'(0));
      err_now = (eq.size() > 0) && (eq[0] == cyc);
      if (fe3 || fe5 || err_now) begin
        chk("k3_frame_err", WMAX'(fe3), WMAX'(err_now));
        chk("k5_frame_err", WMAX'(fe5), WMAX'(err_now));
        if (err_now) void'(eq.pop_front());
        if (fe3) errs++;
      end
    end
    if (req_id != ack_id) begin
      chk("k3_window_count", WMAX'(cnt3), WMAX'(exp_cnt3));
      chk("k5_window_count", WMAX'(cnt5), WMAX'(exp_cnt5));
      chk("k3_done_count", WMAX'(done3), WMAX'(exp_done));
      chk("k5_done_count", WMAX'(done5), WMAX'(exp_done));
      chk("err_count", WMAX'(errs), WMAX'(exp_err));
      chk("pending_expected", WMAX'(q3.size() + q5.size() + eq.size()), WMAX'(0));
      chk("k3_centre_1_1_window", WMAX'(c11_3), WMAX'(exp_c11));
      chk("k5_elem_0_0", WMAX'(c22_5[7:0]), WMAX'(exp_lo5));
      chk("k5_elem_4_4", WMAX'(c22_5[199:192]), WMAX'(exp_hi5));
      cnt3 = 0; cnt5 = 0; done3 = 0; done5 = 0; errs = 0;
      c11_3 = '0; c22_5 = '0;
      ack_id = req_id;
    end
  end

  task automatic drive(input bit v, input logic [7:0] val, input bit fs);
    @(posedge clk); #1;
    pixel_in_valid = v;
    pixel_in       = val;
    frame_start    = fs;
    if (fs) begin
      if (pr != 0 || pc != 0) eq.push_back(cyc + 1);
      pr = 0; pc = 0;
    end
    if (v) begin
      img[pr][pc] = val;
      if (pr >= 2 && pc >= 2) q3.push_back(build(3));
      if (pr >= 4 && pc >= 4) q5.push_back(build(5));
      pc++;
      if (pc == W) begin
        pc = 0;
        pr = (pr == H - 1) ? 0 : pr + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'd0, 1'b0);
  endtask

  task automatic phase(input int c3, input int c5, input int dn, input int er,
                       input logic [71:0] c11, input logic [7:0] lo5, input logic [7:0] hi5);
    idle(4);
    exp_cnt3 = c3; exp_cnt5 = c5; exp_done = dn; exp_err = er;
    exp_c11 = c11; exp_lo5 = lo5; exp_hi5 = hi5;
    req_id++;
    for (int t = 0; t < 20 && ack_id != req_id; t++) @(posedge clk);
    if (ack_id != req_id) begin
      $display("FAIL phase_handshake: got ack %0d expected %0d", ack_id, req_id);
      $fatal(1);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    pixel_in_valid = 1'b0;
    frame_start    = 1'b0;
    rstN           = 1'b0;
    pr = 0; pc = 0;
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
  endtask

  localparam logic [71:0] WIN_F0 = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
  localparam logic [71:0] WIN_F1 = {8'd118, 8'd117, 8'd116, 8'd110, 8'd109, 8'd108, 8'd102, 8'd101, 8'd100};

  initial begin
    rstN = 1'b0; pixel_in = '0; pixel_in_valid = 1'b0; frame_start = 1'b0;
    pr = 0; pc = 0;
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;

    // continuous frame, frame_start at origin raises no error
    for (int i = 0; i < 48; i++) drive(1'b1, 8'(i), i == 0);
    phase(24, 8, 1, 0, WIN_F0, 8'd0, 8'd36);

    // same frame with random valid gaps
    for (int i = 0; i < 48; i++) begin
      repeat ($urandom_range(0, 2)) idle(1);
      drive(1'b1, 8'(i), 1'b0);
    end
    phase(24, 8, 1, 0, WIN_F0, 8'd0, 8'd36);

    // two frames back-to-back, second offset by 100
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 48; i++) drive(1'b1, 8'(i + 100 * f), 1'b0);
    phase(48, 16, 2, 0, WIN_F1, 8'd100, 8'd136);

    // aborted frame: 20 pixels then frame_start with the next pixel
    for (int i = 0; i < 20; i++) drive(1'b1, 8'(200 + i), 1'b0);
    for (int i = 0; i < 48; i++) drive(1'b1, 8'(i), i == 0);
    phase(26, 8, 1, 1, WIN_F0, 8'd0, 8'd36);

    // reset mid-frame then a full frame
    for (int i = 0; i < 30; i++) drive(1'b1, 8'(60 + i), 1'b0);
    idle(3);
    pulse_reset();
    for (int i = 0; i < 48; i++) drive(1'b1, 8'(i), 1'b0);
    phase(34, 8, 1, 0, WIN_F0, 8'd0, 8'd36);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/window_generator.md
WINDOW_GENERATOR -- requirements
Module: window_generator

Interface
REQ-001 Parameter DATA_W, default 8, pixel bit width.
REQ-002 Parameter IMG_W, default 512, pixels per row (>= K).
REQ-003 Parameter IMG_H, default 512, rows per frame (>= K).
REQ-004 Parameter K, default 3, window edge length; odd, 3..7.
REQ-005 clk  input  1  single clock, all logic rising-edge.
REQ-006 rstN  input  1  asynchronous active-low reset.
REQ-007 pixel_in  input  DATA_W  raster-order pixel.
REQ-008 pixel_in_valid  input  1  pixel_in accepted this cycle; no backpressure.
REQ-009 frame_start  input  1  single-cycle pulse; restarts position counters.
REQ-010 window_out  output  K*K*DATA_W  element (r,c) at bits [(r*K+c)*DATA_W +: DATA_W]; r=0 top (oldest) row, c=0 leftmost column.
REQ-011 window_out_valid  output  1  window_out holds a complete in-image window.
REQ-012 out_col  output  $clog2(IMG_W)  centre column of current window.
REQ-013 out_row  output  $clog2(IMG_H)  centre row of current window.
REQ-014 frame_done  output  1  one-cycle pulse with last window of a frame.
REQ-015 frame_err  output  1  one-cycle pulse on frame_start arriving mid-frame.

Function
REQ-016 Internal in_col/in_row counters give position of each accepted pixel; in_col wraps IMG_W-1->0 incrementing in_row; in_row wraps IMG_H-1->0.
REQ-017 K-1 line buffers of IMG_W x DATA_W plus a K x K register window shift one column per accepted pixel; no state changes on cycles with pixel_in_valid=0.
REQ-018 Window never straddles a row boundary: valid only when accepted pixel has in_row >= K-1 and in_col >= K-1.
REQ-019 Latency: window_out_valid asserts exactly 1 cycle after the qualifying pixel is accepted, for exactly 1 cycle; bottom-right element equals that pixel.
REQ-020 out_row = in_row-(K-1)/2, out_col = in_col-(K-1)/2 of the qualifying pixel, registered with window_out.
REQ-021 Windows per frame = (IMG_W-K+1)*(IMG_H-K+1); no border padding.
REQ-022 FSM states IDLE, FILL, RUN: IDLE->FILL on first accepted pixel; FILL->RUN when in_row reaches K-1; RUN->IDLE after pixel (IMG_H-1, IMG_W-1) accepted.
REQ-023 frame_done asserts in the same cycle as the window of pixel (IMG_H-1, IMG_W-1).
REQ-024 Back-to-back frames: pixel following the last pixel is (0,0) of next frame with zero bubble cycles; stale line-buffer data never appears in a valid window.
REQ-025 frame_start with counters at (0,0): no error, no effect besides position restart.
REQ-026 frame_start with counters not at (0,0): frame_err pulses next cycle, counters and FSM restart, partial frame discarded, no frame_done.
REQ-027 frame_start coincident with pixel_in_valid: that pixel is taken as (0,0) of the new frame.
REQ-028 window_out_valid and frame_done never assert from pixels before the most recent frame_start or reset.

Reset
REQ-029 rstN low asynchronously clears counters, FSM to IDLE, window registers, window_out, window_out_valid, out_col, out_row, frame_done, frame_err to 0.
REQ-030 Line-buffer RAM contents are not reset; REQ-018/REQ-028 gating hides them.
REQ-031 Reset mid-frame: next accepted pixel after release is (0,0).

Verification (IMG_W=8, IMG_H=6, DATA_W=8 unless stated; pixel value = raster index)
REQ-032 K=3, continuous valid, 48 pixels -> first valid 1 cycle after pixel 18, centre (1,1), window 0,1,2,8,9,10,16,17,18; 24 windows total; frame_done with window centred (4,6).
REQ-033 K=3, random valid gaps ~50% -> same 24 windows, identical contents/order as REQ-032.
REQ-034 K=5 -> 8 windows; first after pixel 36, centre (2,2), element (0,0)=0, (4,4)=36.
REQ-035 Two frames back-to-back, frame 2 values +100 -> frame 2 first window 100,101,102,108,109,110,116,117,118; no window mixing frames.
REQ-036 frame_start after 20 pixels -> frame_err pulse, no frame_done; next window 1 cycle after 19th new pixel, centre (1,1).
REQ-037 rstN low for 2 cycles after 30 pixels -> all outputs 0 during reset; restart matches REQ-032 exactly.
